// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

    localparam int WORD_BITS = 32;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } uart_rx_state_t;

    function automatic int baud_ticks(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_sync_bit.sv
// N-flop synchroniser for a single asynchronous bit; reset value is selectable.
module uart_sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {STAGES{RESET_VAL}};
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/uart_rx_word.sv
// UART receiver delivering one 32-bit word per frame (start, 32 data LSB first, stop)
// over a valid/ready handshake, with glitch rejection, framing-error and overrun flags.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_line,
    output logic [WORD_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int BAUD_TICKS = baud_ticks(CLK_FREQ_HZ, BAUD_RATE);
    localparam int HALF_TICKS = BAUD_TICKS / 2;
    localparam int TICK_W     = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;
    localparam int WARM_W     = $clog2(SYNC_STAGES + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BAUD_TICKS - 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(HALF_TICKS - 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES);
    localparam logic [5:0]        BIT_LAST  = 6'(WORD_BITS - 1);

    uart_rx_state_t       state;
    uart_rx_state_t       state_next;
    logic [TICK_W-1:0]    tick_cnt;
    logic [5:0]           bit_cnt;
    logic [WORD_BITS-1:0] shift_reg;
    logic [WARM_W-1:0]    warm_cnt;
    logic                 armed;
    logic                 rx_s;
    logic                 tick_last;
    logic                 half_last;
    logic                 deliver;

    uart_sync_bit #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_line),
        .q     (rx_s)
    );

    always_comb begin
        tick_last  = (tick_cnt == TICK_LAST);
        half_last  = (tick_cnt == HALF_LAST);
        state_next = state;
        case (state)
            RX_IDLE:  if (armed && !rx_s)                 state_next = RX_START;
            RX_START: if (half_last)                      state_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick_last && bit_cnt == BIT_LAST) state_next = RX_STOP;
            RX_STOP:  if (tick_last)                      state_next = rx_s ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (rx_s)                           state_next = RX_IDLE;
            default:                                      state_next = RX_IDLE;
        endcase
        deliver = (state == RX_STOP) && tick_last && rx_s;
    end

    // armed only trusts rx_s once the synchroniser has flushed its reset value,
    // so a line held low across reset cannot be mistaken for a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            warm_cnt   <= '0;
            armed      <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state     <= state_next;
            frame_err <= 1'b0;

            if (warm_cnt != WARM_DONE) begin
                warm_cnt <= warm_cnt + WARM_W'(1);
            end else if (rx_s) begin
                armed <= 1'b1;
            end

            case (state)
                RX_IDLE: begin
                    tick_cnt <= '0;
                    if (state_next == RX_START) begin
                        busy <= 1'b1;
                    end
                end
                RX_START: begin
                    if (half_last) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        if (rx_s) begin
                            busy <= 1'b0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                RX_DATA: begin
                    if (tick_last) begin
                        shift_reg <= {rx_s, shift_reg[WORD_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 6'd1;
                        tick_cnt  <= '0;
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                RX_STOP: begin
                    if (tick_last) begin
                        busy     <= 1'b0;
                        tick_cnt <= '0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                default: begin
                    tick_cnt <= '0;
                end
            endcase

            // A consumer accepting in the same cycle frees the slot for the new word.
            if (deliver && (!data_valid || data_ready)) begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
            end else begin
                if (deliver) begin
                    overrun <= 1'b1;
                end
                if (data_valid && data_ready) begin
                    data_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// Self-checking bench for uart_rx_word: a serial transmitter model drives frames and
// received words are compared against the queue of words the model expects to arrive.
module tb_uart_rx_word;

    localparam int BT      = 10;
    localparam int HALF    = BT / 2;
    localparam int SYNC    = 2;
    localparam int LATENCY = SYNC + HALF + 33 * BT + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_line = 1'b1;
    logic        data_ready = 1'b1;
    logic [31:0] data_out;
    logic        data_valid;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] got_q[$];
    int          rise_cnt = 0;
    int          ferr_cnt = 0;
    int          hi_cnt = 0;
    int          last_rise_cyc = 0;
    logic        dv_prev = 1'b0;

    uart_rx_word #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD_RATE   (100_000),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_line    (rx_line),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the handshake on falling edges, half a cycle away from the DUT's updates.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (data_valid && data_ready) got_q.push_back(data_out);
                if (frame_err) ferr_cnt++;
                if (data_valid) hi_cnt++;
                if (data_valid && !dv_prev) begin
                    rise_cnt++;
                    last_rise_cyc = cyc;
                end
            end
            dv_prev = data_valid;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] w, input logic stop_bit, output int fall_cyc);
        rx_line  = 1'b0;
        fall_cyc = cyc;
        step(BT);
        for (int i = 0; i < 32; i++) begin
            rx_line = w[i];
            step(BT);
        end
        rx_line = stop_bit;
        step(BT);
    endtask

    task automatic check_words(input string name, input logic [31:0] exp_q[$]);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL %s count: got %0d words, expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL %s word %0d: got %h, expected %h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        checks++;
        if ({data_out, data_valid, busy, frame_err, overrun} !== 36'h0) begin
            errors++;
            $display("[TB] FAIL reset_values: got %h/%b/%b/%b/%b, expected 0/0/0/0/0",
                     data_out, data_valid, busy, frame_err, overrun);
        end
        rst_n = 1'b1;
        step(6);
        checks++;
        if (busy !== 1'b0 || data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got busy=%b valid=%b, expected 0/0", busy, data_valid);
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] exp_q[$];
        int f, r0, h0, lat;
        data_ready = 1'b1;
        r0 = rise_cnt;
        h0 = hi_cnt;
        send_frame(32'hDEADBEEF, 1'b1, f);
        step(5);
        exp_q.push_back(32'hDEADBEEF);
        check_words("single_frame", exp_q);
        checks++;
        if (rise_cnt - r0 != 1 || hi_cnt - h0 != 1) begin
            errors++;
            $display("[TB] FAIL single_valid_pulse: got rises=%0d high_cycles=%0d, expected 1/1",
                     rise_cnt - r0, hi_cnt - h0);
        end
        lat = last_rise_cyc - f;
        checks++;
        if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
            errors++;
            $display("[TB] FAIL latency: got %0d cycles, expected %0d +/-1", lat, LATENCY);
        end
        checks++;
        if (frame_err !== 1'b0 || overrun !== 1'b0 || ferr_cnt != 0) begin
            errors++;
            $display("[TB] FAIL single_flags: got ferr=%0d overrun=%b, expected 0/0", ferr_cnt, overrun);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] exp_q[$];
        int f, r0, e0;
        r0 = rise_cnt;
        e0 = ferr_cnt;
        rx_line = 1'b0;
        step(3);
        rx_line = 1'b1;
        step(20);
        checks++;
        if (busy !== 1'b0 || rise_cnt != r0 || ferr_cnt != e0) begin
            errors++;
            $display("[TB] FAIL glitch_reject: got busy=%b rises=%0d ferrs=%0d, expected 0/0/0",
                     busy, rise_cnt - r0, ferr_cnt - e0);
        end
        send_frame(32'h00000001, 1'b1, f);
        step(5);
        exp_q.push_back(32'h00000001);
        check_words("after_glitch", exp_q);
    endtask

    task automatic test_frame_error();
        logic [31:0] exp_q[$];
        int f, r0, e0;
        r0 = rise_cnt;
        e0 = ferr_cnt;
        send_frame(32'h12345678, 1'b0, f);
        step(40);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL break_busy: got %b, expected 0", busy);
        end
        rx_line = 1'b1;
        step(20);
        checks++;
        if (ferr_cnt - e0 != 1) begin
            errors++;
            $display("[TB] FAIL frame_err_pulse: got %0d pulse cycles, expected 1", ferr_cnt - e0);
        end
        checks++;
        if (rise_cnt != r0) begin
            errors++;
            $display("[TB] FAIL frame_err_discard: got %0d deliveries, expected 0", rise_cnt - r0);
        end
        got_q.delete();
        send_frame(32'hA5A5A5A5, 1'b1, f);
        step(5);
        exp_q.push_back(32'hA5A5A5A5);
        check_words("after_break", exp_q);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        int f;
        data_ready = 1'b1;
        send_frame(32'hFFFFFFFF, 1'b1, f);
        send_frame(32'h00000000, 1'b1, f);
        step(5);
        exp_q.push_back(32'hFFFFFFFF);
        exp_q.push_back(32'h00000000);
        check_words("back_to_back", exp_q);
    endtask

    task automatic test_overrun();
        logic [31:0] exp_q[$];
        int f;
        data_ready = 1'b0;
        send_frame(32'h11111111, 1'b1, f);
        send_frame(32'h22222222, 1'b1, f);
        step(5);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 32'h11111111) begin
            errors++;
            $display("[TB] FAIL overrun_hold: got valid=%b data=%h, expected 1/11111111", data_valid, data_out);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_flag: got %b, expected 1", overrun);
        end
        data_ready = 1'b1;
        step(1);
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL accept_drop: got valid=%b, expected 0", data_valid);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_sticky: got %b, expected 1", overrun);
        end
        exp_q.push_back(32'h11111111);
        check_words("overrun_accept", exp_q);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] exp_q[$];
        logic [31:0] w;
        int f, r0;
        w = {16'h0000, 16'($urandom)};
        fork
            begin
                send_frame(w, 1'b1, f);
                rx_line = 1'b1;
            end
            begin
                step(17 * BT + HALF);
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL mid_frame_busy: got %b, expected 1", busy);
                end
                rst_n = 1'b0;
                #1;
                checks++;
                if ({data_out, data_valid, busy, frame_err, overrun} !== 36'h0) begin
                    errors++;
                    $display("[TB] FAIL mid_reset_values: got %h/%b/%b/%b/%b, expected 0/0/0/0/0",
                             data_out, data_valid, busy, frame_err, overrun);
                end
                step(3);
                rst_n = 1'b1;
            end
        join
        r0 = rise_cnt;
        step(20);
        checks++;
        if (rise_cnt != r0 || busy !== 1'b0 || got_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL mid_reset_remainder: got rises=%0d busy=%b words=%0d, expected 0/0/0",
                     rise_cnt - r0, busy, got_q.size());
        end
        got_q.delete();
        send_frame(32'hCAFEF00D, 1'b1, f);
        step(5);
        exp_q.push_back(32'hCAFEF00D);
        check_words("after_mid_reset", exp_q);
    endtask

    task automatic test_random_stream();
        logic [31:0] exp_q[$];
        logic [31:0] w;
        int f, e0;
        e0 = ferr_cnt;
        data_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            w = $urandom;
            exp_q.push_back(w);
            send_frame(w, 1'b1, f);
            step($urandom_range(0, 15));
        end
        step(5);
        check_words("random_stream", exp_q);
        checks++;
        if (overrun !== 1'b0 || ferr_cnt != e0) begin
            errors++;
            $display("[TB] FAIL random_flags: got overrun=%b ferrs=%0d, expected 0/0", overrun, ferr_cnt - e0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
        test_random_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
